cursor_navigator: RTL and testbench

Parametrised cursor engine for the Sudoku board. It holds a 4-way heading state machine and the cursor's column/row counters. It turns on rising edges of the left/right controls and moves one cell per step command, either wrapping or saturating at the board edges. It sits between the debounced button front-end and the board renderer/cell-edit logic, and also drives the 4-bit direction bus consumed by downstream counter logic.

---
 rtl/cursor_pkg.sv | 25 ++
 rtl/rise_detect.sv | 25 ++
 rtl/cursor_navigator.sv | 102 ++++++++++
 tb/tb_cursor_navigator.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
// cursor_pkg: heading encoding, direction-bus constants and rotation helpers for the cursor engine
package cursor_pkg;

    typedef enum logic [1:0] {
        F = 2'd0,
        B = 2'd1,
        T = 2'd2,
        C = 2'd3
    } heading_e;

    localparam logic [3:0] DIR_F = 4'b0011;
    localparam logic [3:0] DIR_B = 4'b1100;
    localparam logic [3:0] DIR_T = 4'b0001;
    localparam logic [3:0] DIR_C = 4'b0100;

    // Clockwise order F->B->T->C is the natural encoding order, so a turn is +/-1 mod 4
    function automatic heading_e rotate(heading_e h, logic right);
        return right ? heading_e'(h + 2'd1) : heading_e'(h - 2'd1);
    endfunction

    function automatic logic [3:0] dir_of(heading_e h);
        return h == F ? DIR_F : h == B ? DIR_B : h == T ? DIR_T : DIR_C;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered one-cycle pulse on each rising edge of a level input
module rise_detect (
    input  logic clk,
    input  logic rstn,
    input  logic in_i,
    output logic pulse_o
);

    logic prev_q;
    logic pulse_q;

    // prev starts at 0 so an input already high at reset release counts as a rise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= in_i;
            pulse_q <= in_i & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/cursor_navigator.sv
// cursor_navigator: heading FSM plus wrapping/saturating column/row cursor for the Sudoku board
module cursor_navigator
    import cursor_pkg::*;
#(
    parameter int GRID_N  = 9,
    parameter int COORD_W = 4,
    parameter bit WRAP    = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               turn_right,
    input  logic               turn_left,
    input  logic               step,
    input  logic               home,
    output logic [1:0]         heading,
    output logic [3:0]         dir_bus,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               moved,
    output logic               blocked
);

    localparam logic [COORD_W:0] LAST = (COORD_W + 1)'(GRID_N - 1);

    heading_e           heading_q, heading_d;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic               moved_q, moved_d, blocked_q, blocked_d;
    logic               right_rise, left_rise, step_rise;
    logic               inc, on_row, at_edge, go;
    logic [COORD_W:0]   cur, nxt;

    rise_detect u_right (.clk(clk), .rstn(rstn), .in_i(turn_right), .pulse_o(right_rise));
    rise_detect u_left  (.clk(clk), .rstn(rstn), .in_i(turn_left),  .pulse_o(left_rise));
    rise_detect u_step  (.clk(clk), .rstn(rstn), .in_i(step),       .pulse_o(step_rise));

    // Heading next state: opposing turns in one cycle cancel, home forces F
    always_comb begin
        heading_d = heading_q;
        if (home)
            heading_d = F;
        else if (right_rise ^ left_rise)
            heading_d = rotate(heading_q, right_rise);
    end

    // Heading state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            heading_q <= F;
        else
            heading_q <= heading_d;
    end

    // Steps use the heading held before any turn in the same cycle; F/B count up, B/C move the row
    assign inc     = ~heading_q[1];
    assign on_row  = heading_q[0];
    assign cur     = on_row ? {1'b0, row_q} : {1'b0, col_q};
    assign at_edge = inc ? (cur + 1'b1) > LAST : cur == '0;
    assign nxt     = at_edge ? (inc ? '0 : LAST) : (inc ? cur + 1'b1 : cur - 1'b1);
    assign go      = step_rise & (WRAP | ~at_edge);

    // Position and pulse next state: home wins over any step in the same cycle
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
        if (home) begin
            col_d = '0;
            row_d = '0;
        end else begin
            if (go && on_row)
                row_d = COORD_W'(nxt);
            if (go && !on_row)
                col_d = COORD_W'(nxt);
            moved_d   = go;
            blocked_d = step_rise & ~go;
        end
    end

    // Position and pulse registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q     <= '0;
            row_q     <= '0;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
        end
    end

    assign heading = heading_q;
    assign dir_bus = dir_of(heading_q);
    assign col     = col_q;
    assign row     = row_q;
    assign moved   = moved_q;
    assign blocked = blocked_q;

endmodule

// File: tb/tb_cursor_navigator.sv
// tb_cursor_navigator: scoreboard bench over wrap (9x9), saturate (9x9) and wrap (4x4) instances
module tb_cursor_navigator;

    logic clk;
    logic tr [3];
    logic tl [3];
    logic st [3];
    logic hm [3];
    logic rn [3];

    logic [1:0] hd0, hd1, hd2;
    logic [3:0] db0, db1, db2;
    logic [3:0] c0, r0, c1, r1;
    logic [1:0] c2, r2;
    logic       m0, b0, m1, b1, m2, b2;

    logic [3:0] dtab [4] = '{4'b0011, 4'b1100, 4'b0001, 4'b0100};

    typedef struct {
        int         d;
        int         cyc;
        string      nm;
        logic [1:0] h;
        logic [3:0] c;
        logic [3:0] r;
        logic       m;
        logic       b;
    } exp_t;

    exp_t q[$];
    int   ncnt   = 0;
    int   checks = 0;
    int   errors = 0;
    logic done   = 1'b0;

    cursor_navigator #(.GRID_N(9), .COORD_W(4), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rstn(rn[0]), .turn_right(tr[0]), .turn_left(tl[0]), .step(st[0]), .home(hm[0]),
        .heading(hd0), .dir_bus(db0), .col(c0), .row(r0), .moved(m0), .blocked(b0)
    );

    cursor_navigator #(.GRID_N(9), .COORD_W(4), .WRAP(1'b0)) u_sat (
        .clk(clk), .rstn(rn[1]), .turn_right(tr[1]), .turn_left(tl[1]), .step(st[1]), .home(hm[1]),
        .heading(hd1), .dir_bus(db1), .col(c1), .row(r1), .moved(m1), .blocked(b1)
    );

    cursor_navigator #(.GRID_N(4), .COORD_W(2), .WRAP(1'b1)) u_small (
        .clk(clk), .rstn(rn[2]), .turn_right(tr[2]), .turn_left(tl[2]), .step(st[2]), .home(hm[2]),
        .heading(hd2), .dir_bus(db2), .col(c2), .row(r2), .moved(m2), .blocked(b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] act(int d);
        return d == 0 ? {hd0, db0, c0, r0, m0, b0} :
               d == 1 ? {hd1, db1, c1, r1, m1, b1} :
                        {hd2, db2, 2'b00, c2, 2'b00, r2, m2, b2};
    endfunction

    task automatic ex(int d, int off, string nm, logic [1:0] h, logic [3:0] c, logic [3:0] r, logic m, logic b);
        exp_t e;
        e.d = d; e.cyc = ncnt + off; e.nm = nm;
        e.h = h; e.c = c; e.r = r; e.m = m; e.b = b;
        q.push_back(e);
    endtask

    task automatic wt(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(int d, logic r, logic l, logic s);
        tr[d] = r; tl[d] = l; st[d] = s;
        wt(1);
        tr[d] = 1'b0; tl[d] = 1'b0; st[d] = 1'b0;
        wt(2);
    endtask

    // Monitor: on every falling edge, compare all expectations due this cycle
    always @(negedge clk) begin
        logic [15:0] want, got;
        exp_t        e;
        ncnt = ncnt + 1;
        while (q.size() > 0 && q[0].cyc <= ncnt) begin
            e      = q.pop_front();
            want   = {e.h, dtab[e.h], e.c, e.r, e.m, e.b};
            got    = act(e.d);
            checks = checks + 1;
            if (got !== want) begin
                errors = errors + 1;
                $display("FAIL %s dut%0d got h=%0d dir=%b col=%0d row=%0d mv=%b bl=%b want h=%0d dir=%b col=%0d row=%0d mv=%b bl=%b",
                         e.nm, e.d, got[15:14], got[13:10], got[9:6], got[5:2], got[1], got[0],
                         want[15:14], want[13:10], want[9:6], want[5:2], want[1], want[0]);
            end
        end
        if (done) begin
            if (q.size() > 0) begin
                errors = errors + q.size();
                $display("FAIL unchecked %0d expectations never reached", q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout bench did not finish");
        $fatal(1, "timeout");
    end

    // Stimulus: directed vectors with hand-computed expected states
    initial begin
        for (int i = 0; i < 3; i++) begin
            tr[i] = 1'b0; tl[i] = 1'b0; st[i] = 1'b0; hm[i] = 1'b0; rn[i] = 1'b0;
        end
        wt(2);
        for (int i = 0; i < 3; i++) ex(i, 1, "reset", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        wt(1);
        for (int i = 0; i < 3; i++) rn[i] = 1'b1;
        wt(2);

        for (int i = 1; i <= 4; i++) begin
            ex(0, 3, "turn_right", 2'(i % 4), 4'd0, 4'd0, 1'b0, 1'b0);
            go(0, 1'b1, 1'b0, 1'b0);
        end
        ex(0, 3, "both_turns", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        go(0, 1'b1, 1'b1, 1'b0);
        ex(0, 3, "step_with_left", 2'd3, 4'd1, 4'd0, 1'b1, 1'b0);
        ex(0, 4, "moved_one_cycle", 2'd3, 4'd1, 4'd0, 1'b0, 1'b0);
        go(0, 1'b0, 1'b1, 1'b1);
        ex(0, 3, "left_c_to_t", 2'd2, 4'd1, 4'd0, 1'b0, 1'b0);
        go(0, 1'b0, 1'b1, 1'b0);
        ex(0, 3, "col_dec", 2'd2, 4'd0, 4'd0, 1'b1, 1'b0);
        go(0, 1'b0, 1'b0, 1'b1);
        ex(0, 3, "wrap_col_dec", 2'd2, 4'd8, 4'd0, 1'b1, 1'b0);
        ex(0, 4, "wrap_col_pulse", 2'd2, 4'd8, 4'd0, 1'b0, 1'b0);
        go(0, 1'b0, 1'b0, 1'b1);
        ex(0, 3, "right_t_to_c", 2'd3, 4'd8, 4'd0, 1'b0, 1'b0);
        go(0, 1'b1, 1'b0, 1'b0);
        ex(0, 3, "wrap_row_dec", 2'd3, 4'd8, 4'd8, 1'b1, 1'b0);
        go(0, 1'b0, 1'b0, 1'b1);
        go(0, 1'b1, 1'b0, 1'b0);
        ex(0, 3, "right_f_to_b", 2'd1, 4'd8, 4'd8, 1'b0, 1'b0);
        go(0, 1'b1, 1'b0, 1'b0);
        ex(0, 3, "wrap_row_inc", 2'd1, 4'd8, 4'd0, 1'b1, 1'b0);
        go(0, 1'b0, 1'b0, 1'b1);

        st[0] = 1'b1;
        ex(0, 3, "held_step_move", 2'd1, 4'd8, 4'd1, 1'b1, 1'b0);
        ex(0, 4, "held_step_pulse", 2'd1, 4'd8, 4'd1, 1'b0, 1'b0);
        ex(0, 11, "held_step_once", 2'd1, 4'd8, 4'd1, 1'b0, 1'b0);
        wt(10);
        st[0] = 1'b0;
        wt(2);
        for (int i = 2; i <= 3; i++) begin
            ex(0, 3, "row_inc", 2'd1, 4'd8, 4'(i), 1'b1, 1'b0);
            go(0, 1'b0, 1'b0, 1'b1);
        end
        go(0, 1'b1, 1'b0, 1'b0);
        for (int i = 7; i >= 5; i--) begin
            ex(0, 3, "col_dec_to_5", 2'd2, 4'(i), 4'd3, 1'b1, 1'b0);
            go(0, 1'b0, 1'b0, 1'b1);
        end
        ex(0, 3, "pre_home", 2'd1, 4'd5, 4'd3, 1'b0, 1'b0);
        go(0, 1'b0, 1'b1, 1'b0);
        hm[0] = 1'b1; st[0] = 1'b1;
        ex(0, 2, "home", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        wt(2);
        hm[0] = 1'b0;
        ex(0, 3, "home_release_held", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        wt(5);
        st[0] = 1'b0;
        wt(2);

        for (int i = 1; i <= 8; i++) begin
            ex(1, 3, "sat_step", 2'd0, 4'(i), 4'd0, 1'b1, 1'b0);
            go(1, 1'b0, 1'b0, 1'b1);
        end
        ex(1, 3, "sat_block_col", 2'd0, 4'd8, 4'd0, 1'b0, 1'b1);
        ex(1, 4, "sat_block_pulse", 2'd0, 4'd8, 4'd0, 1'b0, 1'b0);
        go(1, 1'b0, 1'b0, 1'b1);
        go(1, 1'b0, 1'b1, 1'b0);
        ex(1, 3, "sat_block_row", 2'd3, 4'd8, 4'd0, 1'b0, 1'b1);
        ex(1, 4, "sat_block_row_pulse", 2'd3, 4'd8, 4'd0, 1'b0, 1'b0);
        go(1, 1'b0, 1'b0, 1'b1);

        for (int i = 1; i <= 5; i++) begin
            ex(2, 3, "small_wrap", 2'd0, 4'(i % 4), 4'd0, 1'b1, 1'b0);
            go(2, 1'b0, 1'b0, 1'b1);
        end
        st[2] = 1'b1;
        wt(1);
        rn[2] = 1'b0; st[2] = 1'b0;
        ex(2, 1, "async_reset", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        wt(2);
        ex(2, 1, "held_in_reset", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        wt(1);
        rn[2] = 1'b1;
        ex(2, 3, "pending_discarded", 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        wt(3);
        ex(2, 3, "restart", 2'd0, 4'd1, 4'd0, 1'b1, 1'b0);
        go(2, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 20 && q.size() > 0; i++) wt(1);
        done = 1'b1;
    end

endmodule
